// File: rtl/wb_xbar_decode.sv
// -----------------------------------------------------------------------------
// wb_xbar_decode
//   Single-master to NSLV-slave Wishbone address decoder with a slave-ack
//   timeout and error logging.
//
//   A request in IDLE is priority-decoded on address bits SEL_MSB downto
//   SEL_MSB-NSLV+1. Bit SEL_MSB-i selects slave i, and the lowest index wins.
//   A hit latches the grant and moves to BUSY. A miss goes straight to ERR.
//   In BUSY only the granted slave sees cyc/stb. Its ack is forwarded to the
//   master combinationally. If the slave does not ack within TMO cycles, the
//   block moves to ERR. ERR pulses m_err_o for one cycle and then returns to
//   IDLE.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   m_*_i / m_*_o         master-side Wishbone signals
//   s_cyc_o, s_stb_o      one-hot per-slave cycle / strobe
//   s_we/adr/sel/dat_o    broadcast copies of the master signals
//   s_ack_i, s_dat_i      per-slave ack and packed read data (slot i = [i*DW +: DW])
//   err_cnt_o             saturating count of errors (decode miss or timeout)
//   err_adr_o             address of the most recent error
// -----------------------------------------------------------------------------
module wb_xbar_decode #(
    parameter int NSLV    = 7,
    parameter int SEL_MSB = 31,
    parameter int DW      = 32,
    parameter int TMO     = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_cyc_i,
    input  logic                 m_stb_i,
    input  logic                 m_we_i,
    input  logic [31:0]          m_adr_i,
    input  logic [DW/8-1:0]      m_sel_i,
    input  logic [DW-1:0]        m_dat_i,
    output logic [DW-1:0]        m_dat_o,
    output logic                 m_ack_o,
    output logic                 m_err_o,
    output logic [NSLV-1:0]      s_cyc_o,
    output logic [NSLV-1:0]      s_stb_o,
    output logic                 s_we_o,
    output logic [31:0]          s_adr_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic [DW-1:0]        s_dat_o,
    input  logic [NSLV-1:0]      s_ack_i,
    input  logic [NSLV*DW-1:0]   s_dat_i,
    output logic [15:0]          err_cnt_o,
    output logic [31:0]          err_adr_o
);

    localparam int          GW       = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [31:0]     adr_q, adr_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic [31:0]     err_adr_q, err_adr_d;

    logic            dec_hit;
    logic [GW-1:0]   dec_idx;
    logic            g_ack;
    logic [DW-1:0]   g_dat;
    logic [NSLV-1:0] g_onehot;
    logic            busy;
    logic            log_err;
    logic [31:0]     log_adr;

    // Priority decode. The loop scans from the highest index down so that
    // the lowest matching slave is written last and wins.
    // NOTE: every signal driven in an always_comb gets a default at the top.
    // Otherwise a path that skips an assignment would infer a latch.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (m_adr_i[SEL_MSB - i]) begin
                dec_hit = 1'b1;
                dec_idx = GW'(i);
            end
        end
    end

    // Route the granted slave's ack and data, and build its one-hot select.
    always_comb begin
        g_ack    = 1'b0;
        g_dat    = '0;
        g_onehot = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (grant_q == GW'(i)) begin
                g_ack       = s_ack_i[i];
                g_dat       = s_dat_i[i*DW +: DW];
                g_onehot[i] = 1'b1;
            end
        end
    end

    assign busy      = (state_q == BUSY);
    assign s_cyc_o   = busy ? g_onehot : '0;
    assign s_stb_o   = s_cyc_o;
    assign m_ack_o   = busy & g_ack;
    assign m_err_o   = (state_q == ERR);
    assign m_dat_o   = m_ack_o ? g_dat : '0;
    assign s_we_o    = m_we_i;
    assign s_adr_o   = m_adr_i;
    assign s_sel_o   = m_sel_i;
    assign s_dat_o   = m_dat_i;
    assign err_cnt_o = err_cnt_q;
    assign err_adr_o = err_adr_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tmo_d     = tmo_q;
        adr_d     = adr_q;
        err_cnt_d = err_cnt_q;
        err_adr_d = err_adr_q;
        log_err   = 1'b0;
        log_adr   = adr_q;

        unique case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    grant_d = dec_idx;
                    adr_d   = m_adr_i;
                    tmo_d   = '0;
                    if (dec_hit) begin
                        state_d = BUSY;
                    end else begin
                        // The address is latched on this same edge, so log
                        // the live address rather than adr_q.
                        state_d = ERR;
                        log_err = 1'b1;
                        log_adr = m_adr_i;
                    end
                end
            end
            BUSY: begin
                // Ack beats abort, and abort beats timeout.
                if (g_ack) begin
                    state_d = IDLE;
                end else if (!m_cyc_i) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                    log_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (log_err) begin
            err_adr_d = log_adr;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples its pre-edge value, whatever order the statements are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            tmo_q     <= '0;
            adr_q     <= '0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tmo_q     <= tmo_d;
            adr_q     <= adr_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
        end
    end

endmodule

// File: tb/tb_wb_xbar_decode.sv
// -----------------------------------------------------------------------------
// tb_wb_xbar_decode
//   Self-checking bench for wb_xbar_decode (NSLV=7, SEL_MSB=31, DW=32, TMO=4).
//   Each transfer is predicted at transaction level from the decode rule, the
//   slave ack latency, the master abort point and the timeout. The prediction
//   gives the cycle count, ack/err pulses, read data and the error log. It is
//   then compared with what the outputs show cycle by cycle.
// -----------------------------------------------------------------------------
module tb_wb_xbar_decode;

    localparam int NSLV    = 7;
    localparam int SEL_MSB = 31;
    localparam int DW      = 32;
    localparam int TMO     = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 m_cyc_i, m_stb_i, m_we_i;
    logic [31:0]          m_adr_i;
    logic [DW/8-1:0]      m_sel_i;
    logic [DW-1:0]        m_dat_i;
    logic [DW-1:0]        m_dat_o;
    logic                 m_ack_o, m_err_o;
    logic [NSLV-1:0]      s_cyc_o, s_stb_o;
    logic                 s_we_o;
    logic [31:0]          s_adr_o;
    logic [DW/8-1:0]      s_sel_o;
    logic [DW-1:0]        s_dat_o;
    logic [NSLV-1:0]      s_ack_i;
    logic [NSLV*DW-1:0]   s_dat_i;
    logic [15:0]          err_cnt_o;
    logic [31:0]          err_adr_o;

    always #5 clk = ~clk;

    wb_xbar_decode #(
        .NSLV(NSLV), .SEL_MSB(SEL_MSB), .DW(DW), .TMO(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .err_cnt_o(err_cnt_o), .err_adr_o(err_adr_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference error log.
    int unsigned mdl_err_cnt = 0;
    logic [31:0] mdl_err_adr = '0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Lowest slave whose select bit is set, or -1 on a miss.
    function automatic int target(input logic [31:0] adr);
        for (int i = 0; i < NSLV; i++) if (adr[SEL_MSB - i]) return i;
        return -1;
    endfunction

    function automatic logic [NSLV-1:0] onehot(input int t);
        logic [NSLV-1:0] v;
        v = '0;
        if (t >= 0) v[t] = 1'b1;
        return v;
    endfunction

    // One master transfer. Called and returns at posedge+1.
    //   lat      : busy cycle (0 = first) in which the target slave acks
    //   stray    : non-target slave that pulses ack in busy cycle 0, or -1
    //   abort_at : busy cycle in which the master drops cyc, or -1
    task automatic xfer(input string tag, input logic [31:0] adr, input logic [DW-1:0] rdat,
                        input int lat, input int stray, input int abort_at);
        int tgt, ev, kind, exp_busy, b;
        int busy_n, ack_n, err_n, bad, ack_c, err_c;
        bit exp_ack, exp_err, ended;
        logic [DW-1:0]   wdat, got_dat;
        logic [DW/8-1:0] sel;
        logic            we;

        tgt  = target(adr);
        wdat = $urandom;
        sel  = DW/8'($urandom);
        we   = 1'($urandom);

        // Earliest terminating event wins. Ties go ack, then abort, then timeout.
        if (tgt < 0) begin
            exp_busy = 0; exp_ack = 0; exp_err = 1;
        end else begin
            ev = TMO - 1; kind = 2;
            if (abort_at >= 0 && abort_at <= ev) begin ev = abort_at; kind = 1; end
            if (lat <= ev) begin ev = lat; kind = 0; end
            exp_busy = ev + 1;
            exp_ack  = (kind == 0);
            exp_err  = (kind == 2);
        end
        if (exp_err) begin
            if (mdl_err_cnt != 32'hFFFF) mdl_err_cnt++;
            mdl_err_adr = adr;
        end

        busy_n = 0; ack_n = 0; err_n = 0; bad = 0; ack_c = -1; err_c = -1;
        ended = 0; got_dat = '0;

        // Request cycle (IDLE).
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
        m_adr_i = adr; m_sel_i = sel; m_dat_i = wdat;
        s_ack_i = '0;
        for (int i = 0; i < NSLV; i++) s_dat_i[i*DW +: DW] = $urandom;
        #4;
        check({tag, " passthru_adr"}, 96'(s_adr_o), 96'(adr));
        check({tag, " passthru_ctl"}, 96'({s_we_o, s_sel_o, s_dat_o}), 96'({we, sel, wdat}));
        check({tag, " req_idle"}, 96'({s_cyc_o, m_ack_o, m_err_o}), 96'(0));

        for (int c = 1; c <= TMO + 5; c++) begin
            @(posedge clk); #1;
            b = c - 1;
            if (ended || (tgt >= 0 && abort_at >= 0 && b >= abort_at)) begin
                m_cyc_i = 1'b0; m_stb_i = 1'b0;
            end
            s_ack_i = '0;
            for (int i = 0; i < NSLV; i++)
                s_dat_i[i*DW +: DW] = (i == tgt) ? rdat : DW'($urandom);
            if (tgt >= 0 && b == lat) s_ack_i[tgt] = 1'b1;
            if (stray >= 0 && b == 0) s_ack_i[stray] = 1'b1;
            #4;
            if (s_cyc_o != '0) begin
                if (s_cyc_o == onehot(tgt)) busy_n++;
                else bad++;
            end
            if (s_stb_o != s_cyc_o) bad++;
            if (m_ack_o) begin ack_n++; ack_c = c; got_dat = m_dat_o; end
            else if (m_dat_o != '0) bad++;
            if (m_err_o) begin err_n++; err_c = c; end
            if (m_ack_o && m_err_o) bad++;
            if (m_ack_o || m_err_o) ended = 1;
        end
        m_cyc_i = 1'b0; m_stb_i = 1'b0;

        check({tag, " busy_cycles"}, 96'(busy_n), 96'(exp_busy));
        check({tag, " ack_pulses"},  96'(ack_n),  96'(exp_ack));
        check({tag, " err_pulses"},  96'(err_n),  96'(exp_err));
        check({tag, " protocol"},    96'(bad),    96'(0));
        if (exp_ack) begin
            check({tag, " ack_cycle"}, 96'(ack_c), 96'(lat + 1));
            check({tag, " rdata"},     96'(got_dat), 96'(rdat));
        end
        if (exp_err) check({tag, " err_cycle"}, 96'(err_c), 96'(exp_busy + 1));
        check({tag, " err_cnt"}, 96'(err_cnt_o), 96'(mdl_err_cnt));
        check({tag, " err_adr"}, 96'(err_adr_o), 96'(mdl_err_adr));
        @(posedge clk); #1;
    endtask

    // Reset asserted in the middle of BUSY.
    task automatic reset_mid_busy();
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h1000_0000;  // slave 3
        s_ack_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre busy", 96'(s_cyc_o), 96'(onehot(3)));
        rst = 1'b1;
        #1;
        s_ack_i[3] = 1'b1;
        #1;
        check("rst_mid outs", 96'({s_cyc_o, s_stb_o, m_ack_o, m_err_o}), 96'(0));
        check("rst_mid err_cnt", 96'(err_cnt_o), 96'(0));
        check("rst_mid err_adr", 96'(err_adr_o), 96'(0));
        m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
        mdl_err_cnt = 0;
        mdl_err_adr = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #4;
        check("rst_post outs", 96'({s_cyc_o, m_ack_o, m_err_o}), 96'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int mode, sl, lat, stray, abort_at, tgt;
        logic [31:0] adr;

        rst = 1'b1;
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
        s_ack_i = '0; s_dat_i = '0;
        #2;
        check("reset outs", 96'({s_cyc_o, s_stb_o, m_ack_o, m_err_o}), 96'(0));
        @(posedge clk); @(posedge clk); #1;
        check("reset err_cnt", 96'(err_cnt_o), 96'(0));
        check("reset err_adr", 96'(err_adr_o), 96'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        xfer("miss",      32'h0000_1000, 32'h0,        9, -1, -1);
        xfer("read_hit",  32'h2000_0004, 32'hDEADBEEF, 3, -1, -1);
        xfer("timeout",   32'h8000_0000, 32'h0,        9, -1, -1);
        xfer("prio_stray",32'hC000_0000, 32'h1234_5678, 2, 1, -1);
        xfer("ack_at_tmo",32'h0400_0000, 32'hA5A5_0F0F, TMO - 1, -1, -1);
        xfer("abort",     32'h0800_0000, 32'h0,        9, -1, 1);
        xfer("ack_first", 32'h0200_0000, 32'h0BAD_F00D, 0, 3, -1);

        // Randomized transfers.
        for (int n = 0; n < 60; n++) begin
            mode = $urandom_range(0, 3);
            sl   = $urandom_range(0, NSLV - 1);
            case (mode)
                0:       adr = $urandom & 32'h01FF_FFFF;
                1:       adr = ($urandom & 32'h01FF_FFFF) | (32'h1 << (SEL_MSB - sl));
                2:       adr = $urandom | (32'h1 << (SEL_MSB - sl));
                default: adr = $urandom;
            endcase
            tgt = target(adr);
            lat = $urandom_range(0, TMO + 1);
            stray = -1;
            if ($urandom_range(0, 1) == 1) begin
                if (tgt >= 0) stray = (tgt + 1 + $urandom_range(0, NSLV - 2)) % NSLV;
                else          stray = $urandom_range(0, NSLV - 1);
            end
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO - 1) : -1;
            xfer("rand", adr, $urandom, lat, stray, abort_at);
        end

        reset_mid_busy();
        xfer("post_rst_miss", 32'h0000_0040, 32'h0, 9, -1, -1);
        xfer("post_rst_hit",  32'h0300_0000, 32'hCAFE_0001, 1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
